// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Opcode constants name the operations of the shared ALU; anything above
// OP_MAX is treated as an illegal operation and never reaches the ALU.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int OP_NOOP = 0;
  localparam int OP_AND  = 1;
  localparam int OP_CAS  = 2;
  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_CMP  = 5;
  localparam int OP_LUI  = 6;
  localparam int OP_MAX  = OP_LUI;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way grant logic for the ALU arbiter.
// Build option ALU_ARB_RR_EN: when defined, a tie goes to the requester not
// served last (registered pointer, requester 0 wins the first tie after
// reset); when undefined, requester 0 always wins a tie and no pointer exists.
module alu_arb_grant (
`ifdef ALU_ARB_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       take,
  input  logic       take_idx,
`endif
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  logic last;

  // Remember which requester was served by the most recent accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take) begin
      last <= take_idx;
    end
  end

  // One-hot grant; a tie goes to the requester not served last.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`else
  // One-hot grant; requester 0 has fixed priority on a tie.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = 2'b01;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter sharing one combinational ALU between two requesters.
// One operation is in flight at a time: IDLE accepts, EXEC drives the ALU
// for exactly one cycle, RESP holds the result until the owner takes it.
// Build option ALU_ARB_RR_EN selects round-robin tie-breaking (see
// alu_arb_grant); the default build uses fixed priority for requester 0.
//
//   state | meaning
//   IDLE  | ready offered to the granted requester, ALU bus parked at NOOP
//   EXEC  | latched operation on the ALU bus, result captured at cycle end
//   RESP  | rsp_valid to owner, payload held until owner's rsp_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int SEL_W  = 4,
  parameter int COND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [COND_W-1:0] req0_cond,
  input  logic [COND_W-1:0] req1_cond,
  input  logic              req0_sf,
  input  logic              req1_sf,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [COND_W-1:0] alu_cond,
  output logic              alu_sf,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  state_t state;
  logic   owner;
  logic   op_err;

  logic [1:0]        grant;
  logic              accept;
  logic              acc_idx;
  logic [SEL_W-1:0]  in_sel;
  logic [COND_W-1:0] in_cond;
  logic              in_sf;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_ok;

  alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .take     (accept),
    .take_idx (acc_idx),
`endif
    .req_valid(req_valid),
    .grant    (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign acc_idx   = grant[1];

  // Select the payload of the granted requester.
  always_comb begin
    in_sel  = acc_idx ? req1_sel  : req0_sel;
    in_cond = acc_idx ? req1_cond : req0_cond;
    in_sf   = acc_idx ? req1_sf   : req0_sf;
    in_a    = acc_idx ? req1_a    : req0_a;
    in_b    = acc_idx ? req1_b    : req0_b;
    in_ok   = (int'(in_sel) <= OP_MAX);
  end

  // Operation sequencer with registered ALU bus and response payload.
  // An illegal opcode keeps the ALU bus parked at NOOP during EXEC so the
  // ALU never sees an undefined select; the response is forced instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      op_err     <= 1'b0;
      alu_sel    <= '0;
      alu_cond   <= '0;
      alu_sf     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner  <= acc_idx;
            op_err <= !in_ok;
            if (in_ok) begin
              alu_sel  <= in_sel;
              alu_cond <= in_cond;
              alu_sf   <= in_sf;
              alu_a    <= in_a;
              alu_b    <= in_b;
            end
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_sel    <= '0;
          alu_cond   <= '0;
          alu_sf     <= 1'b0;
          alu_a      <= '0;
          alu_b      <= '0;
          rsp_result <= op_err ? '0 : alu_result;
          rsp_zero   <= op_err ? 1'b1 : alu_zero;
          rsp_err    <= op_err;
          rsp_valid  <= {owner, ~owner};
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level reference model
// (phase counter, owner, expected response) runs beside the DUT and every
// output is compared each cycle; directed scenarios add explicit checks.
module tb_alu_arbiter;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]    req0_sel, req1_sel, alu_sel;
  logic [1:0]    req0_cond, req1_cond, alu_cond;
  logic          req0_sf, req1_sf, alu_sf;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [DW-1:0] rsp_result, alu_result;
  logic          rsp_zero, rsp_err, alu_zero;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .req0_cond(req0_cond), .req1_cond(req1_cond),
    .req0_sf(req0_sf), .req1_sf(req1_sf),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_sel(alu_sel), .alu_cond(alu_cond), .alu_sf(alu_sf),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Stand-in ALU outside the DUT.
  function automatic logic [DW-1:0] alu_f(input logic [3:0] s, input logic [1:0] c,
                                          input logic f, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic lt, r;
    case (s)
      4'd1: return a & b;
      4'd2: return (a == b) ? b : a;
      4'd3: return a + b;
      4'd4: return a - b;
      4'd5: begin
        lt = f ? ($signed(a) < $signed(b)) : (a < b);
        case (c)
          2'd0:    r = (a == b);
          2'd1:    r = lt;
          2'd2:    r = !lt && (a != b);
          default: r = (a != b);
        endcase
        return {{(DW-1){1'b0}}, r};
      end
      4'd6: return {b[11:0], 12'h000};
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_cond, alu_sf, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Which requester wins, from the arbitration rule itself.
  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic lst);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      return lst ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return 2'b00;
  endfunction

  // Reference model state.
  bit            started = 0;
  int            phase = 0;     // 0 waiting, 1 operation on ALU, 2 response pending
  logic          m_owner = 1'b0;
  logic          m_last = 1'b1;
  logic [3:0]    m_sel;
  logic [1:0]    m_cond;
  logic          m_sf, m_err, m_zero;
  logic [DW-1:0] m_a, m_b, m_res;
  int            cyc = 0, acc_cyc = 0, lat = -1;
  int            acc_cnt = 0, rsp_cnt = 0, sel_bad = 0;
  logic [1:0]    prev_rv = 2'b00;
  logic [DW-1:0] last_res;
  logic          last_zero, last_err;
  int            grant_log[$];

  always @(negedge clk) begin
    logic [1:0]  er, g;
    logic [54:0] ealu;
    logic        idx;
    cyc++;
    er = (phase == 0) ? exp_grant(req_valid, m_last) : 2'b00;
    if (started) begin
      check_eq("req_ready", req_ready, er);
      check_eq("rsp_valid", rsp_valid, (phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
      if (phase == 2) begin
        check_eq("rsp_result", rsp_result, m_res);
        check_eq("rsp_zero", rsp_zero, m_zero);
        check_eq("rsp_err", rsp_err, m_err);
      end
      ealu = (phase == 1 && !m_err) ? {m_sel, m_cond, m_sf, m_a, m_b} : '0;
      check_eq("alu_bus", {alu_sel, alu_cond, alu_sf, alu_a, alu_b}, ealu);
      if (alu_sel > 4'd6) sel_bad++;
      if (rsp_valid != 2'b00 && prev_rv == 2'b00) lat = cyc - acc_cyc;
    end
    prev_rv = rsp_valid;
    if (!rst_n) begin
      phase  = 0;
      m_last = 1'b1;
    end else begin
      case (phase)
        0: begin
          g = er & req_valid;
          if (g != 2'b00) begin
            idx     = g[1];
            m_owner = idx;
            m_sel   = idx ? req1_sel  : req0_sel;
            m_cond  = idx ? req1_cond : req0_cond;
            m_sf    = idx ? req1_sf   : req0_sf;
            m_a     = idx ? req1_a    : req0_a;
            m_b     = idx ? req1_b    : req0_b;
            m_err   = (m_sel > 4'd6);
            m_res   = m_err ? '0 : alu_f(m_sel, m_cond, m_sf, m_a, m_b);
            m_zero  = m_err ? 1'b1 : (m_res == '0);
            m_last  = idx;
            grant_log.push_back(int'(idx));
            acc_cnt++;
            acc_cyc = cyc;
            phase   = 1;
          end
        end
        1: phase = 2;
        default: begin
          if (rsp_ready[m_owner]) begin
            last_res  = rsp_result;
            last_zero = rsp_zero;
            last_err  = rsp_err;
            rsp_cnt++;
            phase = 0;
          end
        end
      endcase
    end
  end

  task automatic set_req(input int idx, input int sel, input int cond, input bit sf,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (idx == 0) begin
      req0_sel = 4'(sel); req0_cond = 2'(cond); req0_sf = sf; req0_a = a; req0_b = b;
      req_valid[0] = 1'b1;
    end else begin
      req1_sel = 4'(sel); req1_cond = 2'(cond); req1_sf = sf; req1_a = a; req1_b = b;
      req_valid[1] = 1'b1;
    end
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 60 && acc_cnt < n; i++) @(posedge clk);
    check_eq("acc_wait", acc_cnt >= n, 1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 60 && rsp_cnt < n; i++) @(posedge clk);
    check_eq("rsp_wait", rsp_cnt >= n, 1);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int base, gb;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_sel = '0; req1_sel = '0; req0_cond = '0; req1_cond = '0;
    req0_sf = 1'b0; req1_sf = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1;
    @(negedge clk);
    check_eq("rst_rsp_result", rsp_result, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);

    // Single ADD from requester 0.
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    base = acc_cnt;
    set_req(0, 3, 0, 0, 24'd5, 24'd7);
    wait_acc(base + 1); #1;
    req_valid = 2'b00;
    wait_rsp(rsp_cnt + 1);
    check_eq("add_result", last_res, 12);
    check_eq("add_zero", last_zero, 0);
    check_eq("add_err", last_err, 0);
    check_eq("add_latency", lat, 2);

    // Both valid straight from reset, held for four grants.
    do_reset(2);
    base = acc_cnt;
    gb = grant_log.size();
    set_req(0, 1, 0, 0, 24'hF0F0F0, 24'h0FF0FF);
    set_req(1, 2, 0, 0, 24'h000123, 24'h000456);
    wait_acc(base + 4); #1;
    req_valid = 2'b00;
    wait_rsp(rsp_cnt + 1);
    check_eq("tie_g0", grant_log[gb], 0);
`ifdef ALU_ARB_RR_EN
    check_eq("tie_g1", grant_log[gb+1], 1);
    check_eq("tie_g2", grant_log[gb+2], 0);
    check_eq("tie_g3", grant_log[gb+3], 1);
`else
    check_eq("tie_g1", grant_log[gb+1], 0);
    check_eq("tie_g2", grant_log[gb+2], 0);
    check_eq("tie_g3", grant_log[gb+3], 0);
`endif

    // Illegal opcode from requester 1.
    @(posedge clk); #1;
    base = acc_cnt;
    set_req(1, 9, 1, 1, 24'h123456, 24'h654321);
    wait_acc(base + 1); #1;
    req_valid = 2'b00;
    wait_rsp(rsp_cnt + 1);
    check_eq("bad_result", last_res, 0);
    check_eq("bad_zero", last_zero, 1);
    check_eq("bad_err", last_err, 1);

    // SUB 3-3 with response back-pressure.
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    base = acc_cnt;
    set_req(0, 4, 0, 0, 24'd3, 24'd3);
    wait_acc(base + 1); #1;
    req_valid = 2'b11;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 2'b10;
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b00; rsp_ready = 2'b01;
    wait_rsp(rsp_cnt + 1);
    check_eq("sub_result", last_res, 0);
    check_eq("sub_zero", last_zero, 1);
    rsp_ready = 2'b11;

    // Reset while the operation is on the ALU.
    @(posedge clk); #1;
    base = acc_cnt;
    set_req(0, 3, 0, 0, 24'd100, 24'd1);
    wait_acc(base + 1); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_alu_sel", alu_sel, 0);
    @(posedge clk); #1;
    base = acc_cnt;
    set_req(1, 3, 0, 0, 24'd40, 24'd2);
    wait_acc(base + 1); #1;
    req_valid = 2'b00;
    wait_rsp(rsp_cnt + 1);
    check_eq("post_rst_result", last_res, 42);

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      req0_sel  = 4'($urandom_range(0, 15));
      req1_sel  = 4'($urandom_range(0, 15));
      req0_cond = 2'($urandom); req1_cond = 2'($urandom);
      req0_sf   = 1'($urandom); req1_sf   = 1'($urandom);
      req0_a    = ($urandom_range(0, 3) == 0) ? 24'd9 : 24'($urandom);
      req0_b    = ($urandom_range(0, 3) == 0) ? 24'd9 : 24'($urandom);
      req1_a    = 24'($urandom);
      req1_b    = ($urandom_range(0, 3) == 0) ? req1_a : 24'($urandom);
      rst_n     = ($urandom_range(0, 63) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("alu_sel_range", sel_bad, 0);
    check_eq("random_activity", acc_cnt > 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 24, operand/result width.
REQ-002 Parameter: SEL_W, 4, ALU operation-select width.
REQ-003 Parameter: COND_W, 2, condition-code width.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  synchronous, active-low reset.
REQ-006 Ports: req_valid  in  2, and req_ready  out  2; per-requester request handshake, index 0/1.
REQ-007 Ports: req0_sel/req1_sel  in  SEL_W, req0_cond/req1_cond  in  COND_W, req0_sf/req1_sf  in  1, req0_a/req0_b/req1_a/req1_b  in  DATA_W; request payload.
REQ-008 Ports: rsp_valid  out  2, and rsp_ready  in  2; per-requester response handshake.
REQ-009 Ports: rsp_result  out  DATA_W, rsp_zero  out  1, rsp_err  out  1; shared response payload, meaningful only for the asserted rsp_valid bit.
REQ-010 Ports: alu_sel  out  SEL_W, alu_cond  out  COND_W, alu_sf  out  1, alu_a/alu_b  out  DATA_W; drive the shared combinational ALU.
REQ-011 Ports: alu_result  in  DATA_W, alu_zero  in  1; ALU outputs.

Function
REQ-012 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-013 IDLE: req_ready asserted only for the granted requester; other bit 0; rsp_valid = 0.
REQ-014 Grant: a single valid requester is granted; if both are valid, the requester not served last is granted.
REQ-015 Accept (req_valid & req_ready) in IDLE: latch sel/cond/sf/a/b and owner index, update last-served pointer, go EXEC.
REQ-016 EXEC (exactly one cycle): alu_* driven from latched payload; at cycle end capture alu_result/alu_zero into response registers, go RESP.
REQ-017 Latched sel > 6: ALU outputs ignored; capture result 0, zero 1, err 1; otherwise err 0.
REQ-018 RESP: rsp_valid[owner] = 1, other bit 0, payload stable until rsp_ready[owner]; on handshake go IDLE.
REQ-019 Latency: rsp_valid rises 2 cycles after the accept edge; minimum issue interval 3 cycles.
REQ-020 Outside EXEC: alu_sel = 0 (NOOP), alu_cond = 0, alu_sf = 0, alu_a = alu_b = 0.
REQ-021 rsp_ready on the non-owner bit and req_valid changes during EXEC/RESP have no effect; req_ready = 0 outside IDLE.
REQ-022 No new request is accepted in the same cycle as a response handshake; IDLE is re-entered first.

Reset
REQ-023 rst_n low at a clock edge: state IDLE, last-served pointer = 1 (requester 0 wins the first tie), response registers 0, err 0.
REQ-024 Reset mid-operation: in-flight operation dropped, no rsp_valid issued; outputs per REQ-020 the next cycle.

Configuration
REQ-025 With ALU_ARB_RR_EN defined: tie-break per REQ-014 (round-robin).
REQ-026 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins a tie; pointer logic absent.

Structure
REQ-027 Shared package holds the FSM state enum, ALU opcode constants (NOOP=0, AND=1, CAS=2, ADD=3, SUB=4, CMP=5, LUI=6), and the max-valid-opcode constant.
REQ-028 One sub-module, alu_arb_grant: 2-way grant logic, round-robin pointer included; combinational grant, registered pointer.

Verification
REQ-029 Req0 ADD a=5 b=7 cond=0 sf=0, rsp_ready=1 -> rsp_valid[0] 2 cycles after accept, result 12, zero 0, err 0.
REQ-030 Both valid from reset, req0 AND, req1 CAS -> req0 served first, req1 next; with ALU_ARB_RR_EN and both held valid, grants alternate 0,1,0,1.
REQ-031 Req1 sel=9 -> rsp_valid[1], result 0, zero 1, err 1; alu_sel never driven to 9.
REQ-032 Req0 SUB a=b=3, rsp_ready low 5 cycles -> rsp_valid held, result 0, zero 1 stable; req_ready = 00 throughout.
REQ-033 rst_n low during EXEC -> next cycle IDLE, rsp_valid = 00, alu_sel = 0; a later request completes normally.
REQ-034 Fixed-priority build, both valid continuously -> requester 0 granted every time, requester 1 never granted.
